// File: rtl/c499_key_loader.sv
// c499_key_loader: serial key-load controller for the locked c499 core.
// Receives a 40-bit key LSB first plus one even-parity bit over a
// valid/ready stream. On a parity match the key is committed to the core's
// key pins in one edge and the output gate opens. Until then the core sits
// on an all-zero key with its outputs masked.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no key committed, waiting for start
// S_LOAD   | accepting key bits into the shadow register
// S_PARITY | accepting the single parity bit
// S_READY  | key committed, c499 outputs enabled; left only by clear/reset
// S_ERROR  | parity mismatch seen, err held until start or clear
module c499_key_loader #(
  parameter int KEY_BITS = 40,
  parameter int CNT_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 key_bit,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [35:0]          x_key,
  output logic [KEY_BITS-37:0] p_key,
  output logic                 out_en,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PARITY = 3'd2,
    S_READY  = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_BITS - 1);

  state_t              state, state_nxt;
  logic [KEY_BITS-1:0] shadow;
  logic [KEY_BITS-1:0] key_q;
  logic [CNT_W-1:0]    cnt;
  logic                par;
  logic                beat;
  logic                par_ok;

  // A beat is only possible while key_ready is decoded high.
  assign beat   = key_valid && key_ready;
  // Running parity of the 40 key bits combined with the incoming parity bit.
  assign par_ok = (par ^ key_bit) == 1'b0;

  assign x_key = key_q[35:0];
  assign p_key = key_q[KEY_BITS-1:36];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything, including a beat.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_LOAD;
        S_LOAD:   if (beat && cnt == LAST_IDX) state_nxt = S_PARITY;
        S_PARITY: if (beat) state_nxt = par_ok ? S_READY : S_ERROR;
        S_READY:  state_nxt = S_READY;
        S_ERROR:  if (start) state_nxt = S_LOAD;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode straight from the state register.
  always_comb begin
    key_ready = 1'b0;
    busy      = 1'b0;
    out_en    = 1'b0;
    case (state)
      S_LOAD, S_PARITY: begin
        key_ready = 1'b1;
        busy      = 1'b1;
      end
      S_READY: out_en = 1'b1;
      default: ;
    endcase
  end

  // Shadow capture, running parity, atomic commit and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      key_q  <= '0;
      err    <= 1'b0;
    end else if (clear) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      key_q  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            shadow <= '0;
            cnt    <= '0;
            par    <= 1'b0;
            err    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            shadow[cnt] <= key_bit;
            cnt         <= cnt + CNT_W'(1);
            par         <= par ^ key_bit;
          end
        end
        S_PARITY: begin
          if (beat) begin
            // The core key pins only ever see a fully checked key.
            if (par_ok) key_q <= shadow;
            else        err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
